// File: rtl/motor_seq_pkg.sv
// Shared types and helpers for the motor ramp sequencer.
package motor_seq_pkg;

  localparam int MAG_W = 31;

  typedef enum logic [2:0] {
    IDLE, ARM, RAMP, HOLD, REVERSE, DWELL, STOP
  } seq_state_t;

  // One slew step of cur toward tgt. The step never overshoots the target.
  function automatic logic [MAG_W-1:0] slew_toward(input logic [MAG_W-1:0] cur,
                                                   input logic [MAG_W-1:0] tgt,
                                                   input logic [MAG_W-1:0] step);
    logic [MAG_W-1:0] r;
    r = cur;
    if (cur < tgt)      r = ((tgt - cur) <= step) ? tgt : cur + step;
    else if (cur > tgt) r = ((cur - tgt) <= step) ? tgt : cur - step;
    return r;
  endfunction

endpackage

// File: rtl/ramp_tick_gen.sv
// Free-running prescaler; o_tick pulses for one clock every RAMP_DIV clocks.
module ramp_tick_gen #(
  parameter int RAMP_DIV = 100000
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(RAMP_DIV - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  // Wrap at RAMP_DIV-1 back to zero.
  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  // Prescaler register; only reset realigns it.
  always_ff @(posedge i_clk) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign o_tick = (cnt_q == LAST);

endmodule

// File: rtl/motor_ramp_sequencer.sv
// Command sequencer: arms the driver, slews setpoint magnitude, handles
// reversals through zero with a dwell, stop and emergency stop.
module motor_ramp_sequencer
  import motor_seq_pkg::*;
#(
  parameter int               RAMP_DIV    = 100000,
  parameter int               STEP        = 16,
  parameter int               ARM_CYC     = 1000,
  parameter int               DWELL_TICKS = 50,
  parameter logic [MAG_W-1:0] MAX_MAG     = 31'h7FFF_FFFF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [MAG_W-1:0] i_cmd_mag,
  input  logic             i_cmd_dir,
  input  logic             i_cmd_stop,
  input  logic             i_estop,
  output logic [31:0]      o_setpoint,
  output logic             o_dir,
  output logic             o_motor_en,
  output logic             o_pi_en,
  output logic             o_at_target,
  output logic             o_busy
);

  localparam int CNT_MAX = (ARM_CYC > DWELL_TICKS) ? ARM_CYC : DWELL_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] ARM_LAST   = CNT_W'(ARM_CYC - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_TICKS - 1);
  localparam logic [MAG_W-1:0] STEP_M     = MAG_W'(STEP);

  seq_state_t       state_q, state_d;
  logic [MAG_W-1:0] mag_q, mag_d, target_q, target_d, pend_mag_q, pend_mag_d;
  logic             dir_q, dir_d, pend_dir_q, pend_dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             tick, accept, is_stop;
  logic [MAG_W-1:0] eff_mag, slewed;

  ramp_tick_gen #(.RAMP_DIV(RAMP_DIV)) u_tick (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .o_tick (tick)
  );

  // Command handshake and decode; a zero run magnitude behaves like stop.
  always_comb begin
    o_cmd_ready = ((state_q == IDLE) || (state_q == RAMP) || (state_q == HOLD)) && !i_estop;
    accept      = i_cmd_valid && o_cmd_ready;
    eff_mag     = (i_cmd_mag > MAX_MAG) ? MAX_MAG : i_cmd_mag;
    is_stop     = i_cmd_stop || (eff_mag == '0);
    slewed      = slew_toward(mag_q, target_q, STEP_M);
  end

  // Next-state, slew datapath and shared ARM/DWELL counter.
  always_comb begin
    state_d    = state_q;
    mag_d      = mag_q;
    target_d   = target_q;
    dir_d      = dir_q;
    pend_dir_d = pend_dir_q;
    pend_mag_d = pend_mag_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept && !is_stop) begin
          target_d = eff_mag;
          dir_d    = i_cmd_dir;
          cnt_d    = '0;
          state_d  = ARM;
        end
      end
      ARM: begin
        if (cnt_q == ARM_LAST) state_d = RAMP;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      RAMP, HOLD: begin
        // An accepted command takes this cycle; slewing resumes on the next tick.
        if (accept) begin
          if (is_stop) begin
            target_d = '0;
            state_d  = STOP;
          end else if (i_cmd_dir != dir_q) begin
            pend_dir_d = i_cmd_dir;
            pend_mag_d = eff_mag;
            target_d   = '0;
            state_d    = REVERSE;
          end else begin
            target_d = eff_mag;
            state_d  = (eff_mag == mag_q) ? HOLD : RAMP;
          end
        end else if (state_q == RAMP) begin
          if (mag_q == target_q) state_d = HOLD;
          else if (tick)         mag_d   = slewed;
        end
      end
      REVERSE: begin
        if (mag_q == '0) begin
          cnt_d   = '0;
          state_d = DWELL;
        end else if (tick) begin
          mag_d = slewed;
        end
      end
      DWELL: begin
        if (tick) begin
          if (cnt_q == DWELL_LAST) begin
            dir_d    = pend_dir_q;
            target_d = pend_mag_q;
            state_d  = RAMP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (mag_q == '0) state_d = IDLE;
        else if (tick)   mag_d   = slewed;
      end
      default: state_d = IDLE;
    endcase
    // Emergency stop wins over everything, but the applied direction is kept.
    if (i_estop) begin
      state_d    = IDLE;
      mag_d      = '0;
      target_d   = '0;
      pend_dir_d = 1'b0;
      pend_mag_d = '0;
      cnt_d      = '0;
    end
  end

  // State registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      mag_q      <= '0;
      target_q   <= '0;
      dir_q      <= 1'b0;
      pend_dir_q <= 1'b0;
      pend_mag_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      mag_q      <= mag_d;
      target_q   <= target_d;
      dir_q      <= dir_d;
      pend_dir_q <= pend_dir_d;
      pend_mag_q <= pend_mag_d;
      cnt_q      <= cnt_d;
    end
  end

  assign o_setpoint  = {~dir_q, mag_q};
  assign o_dir       = dir_q;
  assign o_motor_en  = (state_q != IDLE);
  assign o_pi_en     = (state_q != IDLE) && (state_q != ARM);
  assign o_at_target = (state_q == HOLD);
  assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_motor_ramp_sequencer.sv
// Directed bench for motor_ramp_sequencer (RAMP_DIV=4, STEP=10, ARM_CYC=3, DWELL_TICKS=2, MAX_MAG=1000).
module tb_motor_ramp_sequencer;

  logic        clk = 1'b0;
  logic        i_rst, i_cmd_valid, i_cmd_dir, i_cmd_stop, i_estop;
  logic [30:0] i_cmd_mag;
  logic        o_cmd_ready, o_dir, o_motor_en, o_pi_en, o_at_target, o_busy;
  logic [31:0] o_setpoint;

  always #5 clk = ~clk;

  motor_ramp_sequencer #(
    .RAMP_DIV(4), .STEP(10), .ARM_CYC(3), .DWELL_TICKS(2), .MAX_MAG(31'd1000)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_mag(i_cmd_mag), .i_cmd_dir(i_cmd_dir), .i_cmd_stop(i_cmd_stop), .i_estop(i_estop),
    .o_setpoint(o_setpoint), .o_dir(o_dir), .o_motor_en(o_motor_en), .o_pi_en(o_pi_en),
    .o_at_target(o_at_target), .o_busy(o_busy)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic        rst, v;
    logic [30:0] mag;
    logic        dir, stop, estop;
    logic [31:0] sp;
    logic        men, pi, rdy, at, busy;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic rst, input logic v, input logic [30:0] mag, input logic dir,
                     input logic [31:0] sp, input logic men, input logic pi, input logic rdy,
                     input logic at, input logic busy);
    vec_t t;
    t.rst = rst; t.v = v; t.mag = mag; t.dir = dir; t.stop = 1'b0; t.estop = 1'b0;
    t.sp = sp; t.men = men; t.pi = pi; t.rdy = rdy; t.at = at; t.busy = busy;
    vecs.push_back(t);
  endtask

  task automatic send(input logic [30:0] m, input logic d, input logic s);
    i_cmd_valid = 1'b1; i_cmd_mag = m; i_cmd_dir = d; i_cmd_stop = s;
    step();
    i_cmd_valid = 1'b0; i_cmd_stop = 1'b0;
  endtask

  // Wait (bounded) for the next setpoint change and compare it.
  task automatic wait_change(input string name, input logic [31:0] exp);
    logic [31:0] prev;
    int n;
    prev = o_setpoint;
    n = 0;
    while (o_setpoint === prev && n < 40) begin step(); n++; end
    if (n >= 40) begin n_chk++; n_fail++; $display("FAIL %s: timeout waiting for %h", name, exp); end
    else chk(name, o_setpoint, exp);
  endtask

  initial begin
    int n;
    i_rst = 1'b1; i_cmd_valid = 1'b0; i_cmd_mag = '0; i_cmd_dir = 1'b0;
    i_cmd_stop = 1'b0; i_estop = 1'b0;

    // Reset, accept mag=25 dir=0, 3 ARM cycles, slew 10/20/25 on ticks, HOLD.
    //   rst v  mag dir  setpoint        men pi rdy at busy
    add(1, 0, 0,  0, 32'h8000_0000, 0, 0, 1, 0, 0);
    add(1, 0, 0,  0, 32'h8000_0000, 0, 0, 1, 0, 0);
    add(0, 1, 25, 0, 32'h8000_0000, 1, 0, 0, 0, 1);
    add(0, 0, 0,  0, 32'h8000_0000, 1, 0, 0, 0, 1);
    add(0, 0, 0,  0, 32'h8000_0000, 1, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 32'h8000_0000, 1, 1, 1, 0, 1);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 32'h8000_000A, 1, 1, 1, 0, 1);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 32'h8000_0014, 1, 1, 1, 0, 1);
    add(0, 0, 0,  0, 32'h8000_0019, 1, 1, 1, 0, 1);
    add(0, 0, 0,  0, 32'h8000_0019, 1, 1, 1, 1, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      i_rst = vecs[i].rst; i_cmd_valid = vecs[i].v; i_cmd_mag = vecs[i].mag;
      i_cmd_dir = vecs[i].dir; i_cmd_stop = vecs[i].stop; i_estop = vecs[i].estop;
      step();
      chk($sformatf("vec%0d setpoint", i), o_setpoint, vecs[i].sp);
      chk($sformatf("vec%0d motor_en", i), 32'(o_motor_en), 32'(vecs[i].men));
      chk($sformatf("vec%0d pi_en", i), 32'(o_pi_en), 32'(vecs[i].pi));
      chk($sformatf("vec%0d ready", i), 32'(o_cmd_ready), 32'(vecs[i].rdy));
      chk($sformatf("vec%0d at_target", i), 32'(o_at_target), 32'(vecs[i].at));
      chk($sformatf("vec%0d busy", i), 32'(o_busy), 32'(vecs[i].busy));
    end
    i_cmd_valid = 1'b0;

    // Reversal from HOLD@25 dir0 to 15 dir1.
    send(15, 1, 0);
    chk("rev ready", 32'(o_cmd_ready), 0);
    chk("rev pi_en", 32'(o_pi_en), 1);
    wait_change("rev mag15", 32'h8000_000F);
    wait_change("rev mag5", 32'h8000_0005);
    wait_change("rev mag0", 32'h8000_0000);
    n = 0;
    while (!o_cmd_ready && n < 20) begin step(); n++; end
    chk("dwell cycles", 32'(n), 8);
    chk("flip setpoint", o_setpoint, 32'h0000_0000);
    chk("flip dir", 32'(o_dir), 1);
    wait_change("fwd mag10", 32'h0000_000A);
    wait_change("fwd mag15", 32'h0000_000F);
    step();
    chk("fwd at_target", 32'(o_at_target), 1);

    // Same-dir update to 25, then stop ramps down and disables.
    send(25, 1, 0);
    wait_change("upd mag25", 32'h0000_0019);
    step();
    chk("upd at_target", 32'(o_at_target), 1);
    send(0, 0, 1);
    chk("stop ready", 32'(o_cmd_ready), 0);
    chk("stop busy", 32'(o_busy), 1);
    wait_change("stop mag15", 32'h0000_000F);
    wait_change("stop mag5", 32'h0000_0005);
    wait_change("stop mag0", 32'h0000_0000);
    chk("stop men at zero", 32'(o_motor_en), 1);
    step();
    chk("stop men", 32'(o_motor_en), 0);
    chk("stop pi_en", 32'(o_pi_en), 0);
    chk("stop ready idle", 32'(o_cmd_ready), 1);
    chk("stop busy idle", 32'(o_busy), 0);

    // Estop during RAMP@20 with a simultaneous command.
    send(30, 0, 0);
    chk("arm setpoint", o_setpoint, 32'h8000_0000);
    wait_change("es mag10", 32'h8000_000A);
    wait_change("es mag20", 32'h8000_0014);
    i_estop = 1'b1; i_cmd_valid = 1'b1; i_cmd_mag = 31'd500; i_cmd_dir = 1'b1;
    #1;
    chk("es ready", 32'(o_cmd_ready), 0);
    step();
    chk("es setpoint", o_setpoint, 32'h8000_0000);
    chk("es motor_en", 32'(o_motor_en), 0);
    chk("es pi_en", 32'(o_pi_en), 0);
    chk("es busy", 32'(o_busy), 0);
    i_estop = 1'b0; i_cmd_valid = 1'b0;
    step();
    chk("es not accepted", 32'(o_busy), 0);

    // Clamp to 1000, with a command held valid through REVERSE/DWELL.
    send(31'd5000, 0, 0);
    wait_change("cl mag10", 32'h8000_000A);
    wait_change("cl mag20", 32'h8000_0014);
    send(15, 1, 0);
    i_cmd_valid = 1'b1; i_cmd_mag = 31'd5000; i_cmd_dir = 1'b1;
    wait_change("cl rev10", 32'h8000_000A);
    wait_change("cl rev0", 32'h8000_0000);
    n = 0;
    while (!o_cmd_ready && n < 20) begin step(); n++; end
    chk("cl dwell cycles", 32'(n), 8);
    chk("cl flip setpoint", o_setpoint, 32'h0000_0000);
    step();
    i_cmd_valid = 1'b0;
    chk("cl held busy", 32'(o_busy), 1);
    chk("cl held ready", 32'(o_cmd_ready), 1);
    wait_change("cl fwd10", 32'h0000_000A);
    n = 0;
    while (!o_at_target && n < 600) begin step(); n++; end
    chk("cl hold reached", 32'(n < 600), 1);
    chk("cl clamp setpoint", o_setpoint, 32'h0000_03E8);

    // Zero-magnitude run command acts as stop.
    send(0, 0, 0);
    chk("zero pi_en", 32'(o_pi_en), 1);
    n = 0;
    while (o_busy && n < 600) begin step(); n++; end
    chk("zero reached idle", 32'(n < 600), 1);
    chk("zero setpoint", o_setpoint, 32'h0000_0000);
    chk("zero motor_en", 32'(o_motor_en), 0);

    // Reset clears the retained direction.
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    chk("rst setpoint", o_setpoint, 32'h8000_0000);
    chk("rst dir", 32'(o_dir), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
